reglk_programmer: RTL and testbench

Bus initiator that programs the six 32-bit register-lock words into the register-lock memory block at boot. On a start pulse it issues full-word writes on the block's memory-mapped port (write enable, width, address, write data) and reads each word back to confirm it. It raises a sticky `locked_o` on success, or `error_o` after bounded retries. It sits between the boot/security controller and the lock register block, and is the only writer of lock words in normal operation.

---
 rtl/reglk_pkg.sv | 21 ++
 rtl/reglk_programmer.sv | 111 +++++++++++
 tb/tb_reglk_programmer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/reglk_pkg.sv
// Shared types and constants for the register-lock programmer and the
// lock register block's memory-mapped port.
package reglk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DONE,
        ST_ERROR
    } reglk_state_e;

    localparam logic [2:0] MEM_W_BYTE  = 3'b000;
    localparam logic [2:0] MEM_W_HALF  = 3'b001;
    localparam logic [2:0] MEM_W_WORD  = 3'b010;
    localparam logic [2:0] MEM_W_UBYTE = 3'b100;
    localparam logic [2:0] MEM_W_UHALF = 3'b101;

    localparam int REGLK_NUM_WORDS = 6;

endpackage

// File: rtl/reglk_programmer.sv
// Boot-time initiator that writes the lock words into the lock block,
// verifies each by readback with bounded retries, then reports locked/error.
module reglk_programmer
    import reglk_pkg::*;
#(
    parameter int          NUM_REGS  = REGLK_NUM_WORDS,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_RETRY = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [NUM_REGS*32-1:0]   lock_cfg_i,
    output logic                     mem_we_o,
    output logic [2:0]               mem_width_o,
    output logic [31:0]              mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    input  logic [31:0]              mem_rdata_i,
    output logic                     busy_o,
    output logic                     locked_o,
    output logic                     error_o,
    output logic [2:0]               fail_idx_o
);

    // Word index is 3 bits wide to match fail_idx_o, so NUM_REGS is limited to 8.
    localparam int          RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [2:0]  LAST_IDX = 3'(NUM_REGS - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    reglk_state_e  state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [2:0]    fail_idx_q, fail_idx_d;
    logic [31:0]   shadow_q [NUM_REGS];
    logic [31:0]   shadow_d [NUM_REGS];
    logic [31:0]   cur_word;
    logic          on_bus;

    assign cur_word = shadow_q[idx_q];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        fail_idx_d = fail_idx_q;
        shadow_d   = shadow_q;
        unique case (state_q)
            // DONE is absent here on purpose: locking is one-shot per reset.
            ST_IDLE, ST_ERROR: begin
                if (start_i) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        shadow_d[k] = lock_cfg_i[32*k +: 32];
                    end
                    idx_d   = '0;
                    retry_d = '0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_READ;
            ST_READ: begin
                if (mem_rdata_i == cur_word) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        retry_d = '0;
                        state_d = ST_WRITE;
                    end
                end else if (retry_q < RETRY_LIM) begin
                    retry_d = retry_q + 1'b1;
                    state_d = ST_WRITE;
                end else begin
                    fail_idx_d = idx_q;
                    state_d    = ST_ERROR;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            retry_q    <= '0;
            fail_idx_q <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            fail_idx_q <= fail_idx_d;
            shadow_q   <= shadow_d;
        end
    end

    // Outputs decode registered state only, so reset clears them asynchronously.
    assign on_bus      = (state_q == ST_WRITE) || (state_q == ST_READ);
    assign mem_we_o    = (state_q == ST_WRITE);
    assign mem_width_o = MEM_W_WORD;
    assign mem_addr_o  = on_bus ? (BASE_ADDR + {27'd0, idx_q, 2'b00}) : 32'd0;
    assign mem_wdata_o = on_bus ? cur_word : 32'd0;
    assign busy_o      = on_bus;
    assign locked_o    = (state_q == ST_DONE);
    assign error_o     = (state_q == ST_ERROR);
    assign fail_idx_o  = fail_idx_q;

endmodule

// File: tb/tb_reglk_programmer.sv
// Directed bench for reglk_programmer with a falling-edge-commit lock memory
// model that can drop a write or force a read to zero.
module tb_reglk_programmer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [191:0]  cfg;
    logic          mem_we;
    logic [2:0]    mem_width;
    logic [31:0]   mem_addr, mem_wdata, mem_rdata;
    logic          busy, locked, error;
    logic [2:0]    fail_idx;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] mem [16];
    logic        drop08  = 1'b0;
    logic        force0c = 1'b0;
    logic [31:0] wlog_a [$];
    logic [31:0] wlog_d [$];

    logic [31:0] exp_a [6];
    logic [31:0] exp_b [6];

    always #5 clk = ~clk;

    reglk_programmer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .lock_cfg_i  (cfg),
        .mem_we_o    (mem_we),
        .mem_width_o (mem_width),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .busy_o      (busy),
        .locked_o    (locked),
        .error_o     (error),
        .fail_idx_o  (fail_idx)
    );

    assign mem_rdata = (force0c && mem_addr == 32'h0C) ? 32'h0 : mem[mem_addr[5:2]];

    always @(negedge clk) begin
        if (mem_we) begin
            wlog_a.push_back(mem_addr);
            wlog_d.push_back(mem_wdata);
            if (drop08 && mem_addr == 32'h08) drop08 = 1'b0;
            else mem[mem_addr[5:2]] = mem_wdata;
        end
    end

    task automatic prep();
        for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_BEEF;
        wlog_a.delete();
        wlog_d.delete();
        drop08  = 1'b0;
        force0c = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pulses start so the next rising edge (cycle 0) accepts it; returns #1 after that edge.
    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts rising edges after cycle 0 until locked or error, bounded.
    task automatic wait_end(output int cyc);
        cyc = 0;
        while (!locked && !error && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        cfg   = '0;
        #3;
        nvec++; if (mem_we !== 1'b0)        begin nerr++; $display("FAIL reset_we: got %0b want 0", mem_we); end
        nvec++; if (mem_width !== 3'b010)   begin nerr++; $display("FAIL reset_width: got %b want 010", mem_width); end
        nvec++; if (mem_addr !== 32'h0)     begin nerr++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        nvec++; if (mem_wdata !== 32'h0)    begin nerr++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
        nvec++; if ({busy, locked, error} !== 3'b000) begin nerr++; $display("FAIL reset_flags: got %b want 000", {busy, locked, error}); end
        nvec++; if (fail_idx !== 3'd0)      begin nerr++; $display("FAIL reset_fail_idx: got %0d want 0", fail_idx); end
    endtask

    task automatic test_clean();
        int cyc;
        prep();
        apply_reset();
        cfg = {32'hFFFF_FFFF, 32'h0000_00FF, 32'hA5A5_A5A5, 32'd1, 32'd2, 32'd3};
        do_start();
        nvec++; if (busy !== 1'b1)     begin nerr++; $display("FAIL clean_busy_rise: got %0b want 1", busy); end
        nvec++; if (mem_we !== 1'b1)   begin nerr++; $display("FAIL clean_first_we: got %0b want 1", mem_we); end
        wait_end(cyc);
        nvec++; if (cyc !== 12)        begin nerr++; $display("FAIL clean_cycles: got %0d want 12", cyc); end
        nvec++; if (locked !== 1'b1 || error !== 1'b0 || busy !== 1'b0)
            begin nerr++; $display("FAIL clean_flags: got l%0b e%0b b%0b want l1 e0 b0", locked, error, busy); end
        nvec++; if (mem_addr !== 32'h0 || mem_we !== 1'b0)
            begin nerr++; $display("FAIL clean_idle_bus: got we%0b addr %h want we0 addr 0", mem_we, mem_addr); end
        nvec++; if (wlog_a.size() !== 6) begin nerr++; $display("FAIL clean_nwrites: got %0d want 6", wlog_a.size()); end
        for (int k = 0; k < 6 && k < wlog_a.size(); k++) begin
            nvec++;
            if (wlog_a[k] !== 32'(4*k) || wlog_d[k] !== exp_a[k])
                begin nerr++; $display("FAIL clean_write%0d: got %h=%h want %h=%h", k, wlog_a[k], wlog_d[k], 32'(4*k), exp_a[k]); end
        end
    endtask

    task automatic test_retry();
        int cyc, n08;
        prep();
        apply_reset();
        drop08 = 1'b1;
        do_start();
        wait_end(cyc);
        n08 = 0;
        foreach (wlog_a[i]) if (wlog_a[i] == 32'h08) n08++;
        nvec++; if (cyc !== 14)        begin nerr++; $display("FAIL retry_cycles: got %0d want 14", cyc); end
        nvec++; if (locked !== 1'b1 || error !== 1'b0)
            begin nerr++; $display("FAIL retry_flags: got l%0b e%0b want l1 e0", locked, error); end
        nvec++; if (n08 !== 2)         begin nerr++; $display("FAIL retry_word2_writes: got %0d want 2", n08); end
        nvec++; if (wlog_a.size() !== 7) begin nerr++; $display("FAIL retry_nwrites: got %0d want 7", wlog_a.size()); end
    endtask

    task automatic test_fail();
        int cyc, n0c;
        prep();
        apply_reset();
        force0c = 1'b1;
        do_start();
        wait_end(cyc);
        n0c = 0;
        foreach (wlog_a[i]) if (wlog_a[i] == 32'h0C) n0c++;
        nvec++; if (cyc !== 12)        begin nerr++; $display("FAIL fail_cycles: got %0d want 12", cyc); end
        nvec++; if (error !== 1'b1 || locked !== 1'b0 || busy !== 1'b0)
            begin nerr++; $display("FAIL fail_flags: got e%0b l%0b b%0b want e1 l0 b0", error, locked, busy); end
        nvec++; if (fail_idx !== 3'd3) begin nerr++; $display("FAIL fail_idx: got %0d want 3", fail_idx); end
        nvec++; if (n0c !== 3)         begin nerr++; $display("FAIL fail_word3_writes: got %0d want 3", n0c); end
        force0c = 1'b0;
        wlog_a.delete();
        wlog_d.delete();
        do_start();
        nvec++; if (error !== 1'b0 || busy !== 1'b1)
            begin nerr++; $display("FAIL fail_restart_flags: got e%0b b%0b want e0 b1", error, busy); end
        nvec++; if (mem_addr !== 32'h0 || mem_we !== 1'b1)
            begin nerr++; $display("FAIL fail_restart_addr: got we%0b addr %h want we1 addr 0", mem_we, mem_addr); end
        wait_end(cyc);
        nvec++; if (cyc !== 12 || locked !== 1'b1)
            begin nerr++; $display("FAIL fail_restart_done: got cyc %0d l%0b want cyc 12 l1", cyc, locked); end
    endtask

    task automatic test_start_ignored();
        int lock_cyc;
        logic data_ok;
        prep();
        apply_reset();
        cfg = {32'hFFFF_FFFF, 32'h0000_00FF, 32'hA5A5_A5A5, 32'd1, 32'd2, 32'd3};
        do_start();
        lock_cyc = -1;
        for (int c = 1; c <= 24; c++) begin
            start = (c == 3 || c == 20);
            if (c == 2) cfg = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                               32'h4444_4444, 32'h5555_5555, 32'h6666_6666};
            @(posedge clk);
            #1 start = 1'b0;
            if (locked && lock_cyc < 0) lock_cyc = c;
        end
        data_ok = (wlog_a.size() == 6);
        for (int k = 0; k < 6 && k < wlog_a.size(); k++)
            if (wlog_d[k] !== exp_a[k] || wlog_a[k] !== 32'(4*k)) data_ok = 1'b0;
        nvec++; if (lock_cyc !== 12)   begin nerr++; $display("FAIL ign_lock_cycle: got %0d want 12", lock_cyc); end
        nvec++; if (locked !== 1'b1 || busy !== 1'b0)
            begin nerr++; $display("FAIL ign_stay_done: got l%0b b%0b want l1 b0", locked, busy); end
        nvec++; if (data_ok !== 1'b1)  begin nerr++; $display("FAIL ign_captured_data: got %0d writes ok=%0b want 6 ok=1", wlog_a.size(), data_ok); end
    endtask

    task automatic test_async_reset();
        int cyc;
        prep();
        apply_reset();
        cfg = {32'hFFFF_FFFF, 32'h0000_00FF, 32'hA5A5_A5A5, 32'd1, 32'd2, 32'd3};
        do_start();
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        nvec++; if ({mem_we, busy, locked, error} !== 4'b0000)
            begin nerr++; $display("FAIL arst_flags: got %b want 0000", {mem_we, busy, locked, error}); end
        nvec++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_width !== 3'b010)
            begin nerr++; $display("FAIL arst_bus: got %h/%h/%b want 0/0/010", mem_addr, mem_wdata, mem_width); end
        @(negedge clk);
        rst_n = 1'b1;
        wlog_a.delete();
        wlog_d.delete();
        do_start();
        wait_end(cyc);
        nvec++; if (cyc !== 12 || locked !== 1'b1)
            begin nerr++; $display("FAIL arst_rerun: got cyc %0d l%0b want cyc 12 l1", cyc, locked); end
        nvec++; if (wlog_a.size() !== 6 || wlog_d[5] !== exp_a[5])
            begin nerr++; $display("FAIL arst_rerun_writes: got %0d writes want 6", wlog_a.size()); end
    endtask

    initial begin
        exp_a = '{32'd3, 32'd2, 32'd1, 32'hA5A5_A5A5, 32'h0000_00FF, 32'hFFFF_FFFF};
        exp_b = '{32'h6666_6666, 32'h5555_5555, 32'h4444_4444,
                  32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        test_reset();
        test_clean();
        test_retry();
        test_fail();
        test_start_ignored();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
